// File: rtl/io_bus_arbiter.sv
// Arbitrates the CPU data port and the debug monitor onto the I/O device bus.
// Registered round-robin owner with a monitor lock that holds off the CPU.
module io_bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wd,
  output logic [DW-1:0] cpu_rd,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          mon_req,
  input  logic          mon_we,
  input  logic [AW-1:0] mon_addr,
  input  logic [DW-1:0] mon_wd,
  output logic [DW-1:0] mon_rd,
  output logic          mon_ack,
  input  logic          mon_lock,
  output logic          dev_we,
  output logic [AW-1:0] dev_addr,
  output logic [DW-1:0] dev_wd,
  input  logic [DW-1:0] dev_rd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    MON  = 2'd2
  } own_t;

  own_t state, state_nxt;
  own_t last, last_nxt;

  logic cpu_go, mon_go;
  logic cpu_elig, mon_elig;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= MON;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // Owner only gets the bus while it still holds req; a drop is an abort.
  assign cpu_go = ~reset & (state == CPU) & cpu_req;
  assign mon_go = ~reset & (state == MON) & mon_req;

  always_comb begin
    dev_we   = 1'b0;
    dev_addr = '0;
    dev_wd   = '0;
    cpu_ack  = 1'b0;
    mon_ack  = 1'b0;
    cpu_rd   = '0;
    mon_rd   = '0;
    unique case (1'b1)
      cpu_go: begin
        dev_we   = cpu_we;
        dev_addr = cpu_addr;
        dev_wd   = cpu_wd;
        cpu_ack  = 1'b1;
        cpu_rd   = dev_rd;
      end
      mon_go: begin
        dev_we   = mon_we;
        dev_addr = mon_addr;
        dev_wd   = mon_wd;
        mon_ack  = 1'b1;
        mon_rd   = dev_rd;
      end
      default: ;
    endcase
  end

  assign cpu_stall = cpu_req & ~cpu_ack;

  // A requester acked this cycle is masked so its held req is not regranted.
  assign cpu_elig = cpu_req & ~cpu_ack & ~mon_lock;
  assign mon_elig = mon_req & ~mon_ack;

  always_comb begin
    last_nxt  = last;
    state_nxt = IDLE;
    if (cpu_ack)
      last_nxt = CPU;
    else if (mon_ack)
      last_nxt = MON;
    unique case (1'b1)
      cpu_elig & mon_elig:
        state_nxt = (last == CPU) ? MON : CPU;
      cpu_elig & ~mon_elig:
        state_nxt = CPU;
      mon_elig & ~cpu_elig:
        state_nxt = MON;
      default:
        state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed scenarios plus randomized traffic for io_bus_arbiter,
// checked every cycle against a grant-level model of the arbiter.
module tb_io_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, mon_req, mon_we, mon_lock;
  logic [31:0] cpu_addr, cpu_wd, mon_addr, mon_wd, dev_rd;
  logic [31:0] cpu_rd, mon_rd, dev_addr, dev_wd;
  logic        cpu_ack, cpu_stall, mon_ack, dev_we;

  int n_chk = 0;
  int n_fail = 0;

  io_bus_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_ack(cpu_ack),
    .cpu_stall(cpu_stall),
    .mon_req(mon_req), .mon_we(mon_we),
    .mon_addr(mon_addr), .mon_wd(mon_wd),
    .mon_rd(mon_rd), .mon_ack(mon_ack),
    .mon_lock(mon_lock),
    .dev_we(dev_we), .dev_addr(dev_addr),
    .dev_wd(dev_wd), .dev_rd(dev_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: who holds the bus (0 none, 1 cpu, 2 mon)
  // and who was served most recently.
  int m_own = 0;
  int m_last = 2;
  bit started = 0;

  always @(posedge clk) begin
    bit ca, ma, ce, me;
    if (reset) begin
      m_own = 0;
      m_last = 2;
    end else begin
      ca = (m_own == 1) && cpu_req;
      ma = (m_own == 2) && mon_req;
      if (ca) m_last = 1;
      if (ma) m_last = 2;
      ce = cpu_req && !ca && !mon_lock;
      me = mon_req && !ma;
      if (ce && me) m_own = 3 - m_last;
      else if (ce) m_own = 1;
      else if (me) m_own = 2;
      else m_own = 0;
    end
    started = 1;
  end

  always @(negedge clk) begin
    bit ca, ma, we;
    logic [31:0] a, d;
    if (started) begin
      ca = !reset && (m_own == 1) && cpu_req;
      ma = !reset && (m_own == 2) && mon_req;
      we = ca ? cpu_we : (ma ? mon_we : 1'b0);
      a  = ca ? cpu_addr : (ma ? mon_addr : 32'h0);
      d  = ca ? cpu_wd : (ma ? mon_wd : 32'h0);
      chk("cpu_ack", {31'b0, cpu_ack}, {31'b0, ca});
      chk("mon_ack", {31'b0, mon_ack}, {31'b0, ma});
      chk("cpu_rd", cpu_rd, ca ? dev_rd : 32'h0);
      chk("mon_rd", mon_rd, ma ? dev_rd : 32'h0);
      chk("dev_we", {31'b0, dev_we}, {31'b0, we});
      chk("dev_addr", dev_addr, a);
      chk("dev_wd", dev_wd, d);
      chk("cpu_stall", {31'b0, cpu_stall},
          {31'b0, cpu_req && !ca});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wd = 0;
    mon_req = 0; mon_we = 0; mon_addr = 0; mon_wd = 0;
    mon_lock = 0;
  endtask

  task automatic do_reset();
    tick();
    clr();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic idle(int n);
    clr();
    repeat (n) tick();
  endtask

  initial begin
    bit ca_s, ma_s;
    int rst_cnt;
    reset = 1;
    clr();
    dev_rd = 0;
    repeat (2) tick();
    reset = 0;

    // single CPU write
    tick();
    cpu_req = 1; cpu_we = 1;
    cpu_addr = 32'h10; cpu_wd = 32'hDEADBEEF;
    mid();
    chk("t1_c1_ack", {31'b0, cpu_ack}, 32'd0);
    tick();
    mid();
    chk("t1_c2_ack", {31'b0, cpu_ack}, 32'd1);
    chk("t1_c2_we", {31'b0, dev_we}, 32'd1);
    chk("t1_c2_addr", dev_addr, 32'h10);
    chk("t1_c2_wd", dev_wd, 32'hDEADBEEF);
    tick();
    clr();
    mid();
    chk("t1_c3_ack", {31'b0, cpu_ack}, 32'd0);
    chk("t1_c3_we", {31'b0, dev_we}, 32'd0);

    // contention, CPU wins first after reset
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
    mon_req = 1; mon_we = 1; mon_addr = 32'h24;
    mon_wd = 32'h5;
    for (int k = 2; k <= 5; k++) begin
      tick();
      mid();
      chk($sformatf("t2_c%0d_cack", k),
          {31'b0, cpu_ack}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t2_c%0d_mack", k),
          {31'b0, mon_ack}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("t2_c%0d_we", k),
          {31'b0, dev_we}, (k % 2 == 1) ? 32'd1 : 32'd0);
    end
    idle(2);

    // monitor lock holds the CPU off
    mon_lock = 1;
    cpu_req = 1; cpu_addr = 32'h40;
    for (int i = 1; i <= 10; i++) begin
      mid();
      chk($sformatf("t3_c%0d_ack", i), {31'b0, cpu_ack}, 32'd0);
      chk($sformatf("t3_c%0d_stall", i),
          {31'b0, cpu_stall}, 32'd1);
      tick();
    end
    mon_lock = 0;
    mid();
    chk("t3_c11_ack", {31'b0, cpu_ack}, 32'd0);
    tick();
    mid();
    chk("t3_c12_ack", {31'b0, cpu_ack}, 32'd1);
    idle(2);

    // monitor read path
    dev_rd = 32'hA5A5A5A5;
    mon_req = 1; mon_addr = 32'h30;
    mid();
    chk("t4_c1_mrd", mon_rd, 32'h0);
    tick();
    mid();
    chk("t4_c2_mack", {31'b0, mon_ack}, 32'd1);
    chk("t4_c2_mrd", mon_rd, 32'hA5A5A5A5);
    chk("t4_c2_crd", cpu_rd, 32'h0);
    tick();
    clr();
    mid();
    chk("t4_c3_mrd", mon_rd, 32'h0);
    idle(2);

    // abort: req dropped while owning
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h50;
    tick();
    cpu_req = 0;
    mid();
    chk("t5_c2_ack", {31'b0, cpu_ack}, 32'd0);
    chk("t5_c2_we", {31'b0, dev_we}, 32'd0);
    tick();
    mid();
    chk("t5_c3_ack", {31'b0, cpu_ack}, 32'd0);
    idle(2);

    // reset mid-flight
    do_reset();
    cpu_req = 1; cpu_addr = 32'h60;
    mon_req = 1; mon_we = 1; mon_addr = 32'h64;
    mon_wd = 32'h77;
    tick();
    mid();
    chk("t6_c2_cack", {31'b0, cpu_ack}, 32'd1);
    tick();
    reset = 1;
    for (int c = 3; c <= 4; c++) begin
      mid();
      chk($sformatf("t6_c%0d_acks", c),
          {30'b0, cpu_ack, mon_ack}, 32'd0);
      chk($sformatf("t6_c%0d_we", c), {31'b0, dev_we}, 32'd0);
      chk($sformatf("t6_c%0d_addr", c), dev_addr, 32'h0);
      chk($sformatf("t6_c%0d_wd", c), dev_wd, 32'h0);
      tick();
    end
    reset = 0;
    mid();
    chk("t6_c5_acks", {30'b0, cpu_ack, mon_ack}, 32'd0);
    tick();
    mid();
    chk("t6_c6_cack", {31'b0, cpu_ack}, 32'd1);
    chk("t6_c6_mack", {31'b0, mon_ack}, 32'd0);
    idle(2);

    // randomized traffic under protocol rules
    ca_s = 0; ma_s = 0; rst_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      dev_rd = $urandom;
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) reset = 0;
      end else if ($urandom_range(0, 199) == 0) begin
        reset = 1;
        rst_cnt = $urandom_range(1, 2);
      end
      if ($urandom_range(0, 19) == 0) mon_lock = ~mon_lock;
      if (!cpu_req || ca_s) begin
        cpu_req = (!cpu_req) ? $urandom_range(0, 1) == 1
                             : $urandom_range(0, 1) == 1;
        cpu_we = $urandom_range(0, 1) == 1;
        cpu_addr = $urandom;
        cpu_wd = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        cpu_req = 0;
      end
      if (!mon_req || ma_s) begin
        mon_req = $urandom_range(0, 1) == 1;
        mon_we = $urandom_range(0, 1) == 1;
        mon_addr = $urandom;
        mon_wd = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        mon_req = 0;
      end
      mid();
      ca_s = cpu_ack;
      ma_s = mon_ack;
    end
    reset = 0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
